// File: rtl/mul_share_pkg.sv
// Shared types and constants for the multiplier-sharing scheduler.
package mul_share_pkg;

    localparam int OP_W     = 8;   // operand width
    localparam int P_W      = 16;  // product width
    localparam int APPROX_L = 2;   // low x bits dropped in approximate mode
    localparam int CORR_POS = 8;   // bit position of the correction terms
    localparam int ID_MAX_W = 3;   // enough to name up to 8 requesters

    typedef struct packed {
        logic [OP_W-1:0]     x;
        logic [OP_W-1:0]     y;
        logic                approx;
        logic [ID_MAX_W-1:0] id;
    } req_t;

endpackage

// File: rtl/mul_mode_unit.sv
// Combinational 8x8 multiplier with exact and l=2 approximate modes.
module mul_mode_unit
    import mul_share_pkg::*;
(
    input  logic [OP_W-1:0] i_x,
    input  logic [OP_W-1:0] i_y,
    input  logic            i_approx,
    output logic [P_W-1:0]  o_z
);

    logic [P_W-1:0] w_exact;
    logic [P_W-1:0] w_trunc;
    logic [P_W-1:0] w_corr;
    logic           w_c_lo;
    logic           w_c_hi;

    // Exact product, truncated-x product plus top-bit correction, then mode select.
    always_comb begin
        w_exact = P_W'(i_x) * P_W'(i_y);
        w_trunc = (P_W'(i_y) * P_W'(i_x[OP_W-1:APPROX_L])) << APPROX_L;
        w_c_lo  = (i_x[0] & i_y[OP_W-1]) | (i_x[1] & i_y[OP_W-2]);
        w_c_hi  = i_x[1] & i_y[OP_W-1];
        w_corr  = (P_W'(w_c_lo) << CORR_POS) + (P_W'(w_c_hi) << CORR_POS);
        o_z     = i_approx ? (w_trunc + w_corr) : w_exact;
    end

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one multiplier across N_REQ requesters,
// with a two-stage (operand, product) valid/ready pipeline.
module mul_share_sched
    import mul_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*OP_W-1:0] req_x,
    input  logic [N_REQ*OP_W-1:0] req_y,
    input  logic [N_REQ-1:0]      req_approx,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [P_W-1:0]        rsp_z,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_approx,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    logic [ID_MAX_W-1:0] r_ptr;
    req_t                r_s1;
    logic                r_s1_valid;
    logic                r_s2_valid;
    logic [P_W-1:0]      r_s2_z;
    logic [ID_MAX_W-1:0] r_s2_id;
    logic                r_s2_approx;
    logic [CNT_W-1:0]    r_op_count;

    logic                w_s1_ready;
    logic                w_s2_ready;
    logic                w_gnt_any;
    logic [ID_MAX_W-1:0] w_gnt_id;
    logic [N_REQ-1:0]    w_grant;
    req_t                w_gnt_req;
    logic                w_accept;
    logic [P_W-1:0]      w_s1_z;
    int unsigned         w_ptr_u;

    assign w_s2_ready = !r_s2_valid || rsp_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_ptr_u    = 32'(r_ptr);
    assign w_accept   = w_gnt_any && w_s1_ready;

    // Rotate-priority search: indices at or above ptr first, then the wrapped low ones.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_grant   = '0;
        w_gnt_req = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_gnt_any && req_valid[i] && (i >= w_ptr_u)) begin
                w_gnt_any        = 1'b1;
                w_gnt_id         = ID_MAX_W'(i);
                w_grant[i]       = 1'b1;
                w_gnt_req.x      = req_x[i*OP_W +: OP_W];
                w_gnt_req.y      = req_y[i*OP_W +: OP_W];
                w_gnt_req.approx = req_approx[i];
                w_gnt_req.id     = ID_MAX_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_gnt_any && req_valid[i] && (i < w_ptr_u)) begin
                w_gnt_any        = 1'b1;
                w_gnt_id         = ID_MAX_W'(i);
                w_grant[i]       = 1'b1;
                w_gnt_req.x      = req_x[i*OP_W +: OP_W];
                w_gnt_req.y      = req_y[i*OP_W +: OP_W];
                w_gnt_req.approx = req_approx[i];
                w_gnt_req.id     = ID_MAX_W'(i);
            end
        end
    end

    // Reset is folded in so req_ready is 0 as soon as rst rises, not at the next edge.
    always_comb begin
        req_ready = '0;
        if (w_s1_ready && !rst) begin
            req_ready = w_grant;
        end
    end

    // Round-robin pointer moves past the granted requester on each accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            if (w_gnt_id == ID_MAX_W'(N_REQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_gnt_id + 1'b1;
            end
        end
    end

    // Operand stage: refills whenever it can move on, so drain and refill share a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1 <= w_gnt_req;
            end
        end
    end

    mul_mode_unit u_mode (
        .i_x      (r_s1.x),
        .i_y      (r_s1.y),
        .i_approx (r_s1.approx),
        .o_z      (w_s1_z)
    );

    // Product stage: payload only changes when downstream can take it, keeping rsp_* stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_z      <= '0;
            r_s2_id     <= '0;
            r_s2_approx <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_z      <= w_s1_z;
                r_s2_id     <= r_s1.id;
                r_s2_approx <= r_s1.approx;
            end
        end
    end

    // Completed-response counter, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (r_s2_valid && rsp_ready) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign rsp_valid  = r_s2_valid;
    assign rsp_z      = r_s2_z;
    assign rsp_id     = ID_W'(r_s2_id);
    assign rsp_approx = r_s2_approx;
    assign busy       = r_s1_valid || r_s2_valid;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched with hand-computed expectations.
module tb_mul_share_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic [3:0]  req_approx;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_z;
    logic [1:0]  rsp_id;
    logic        rsp_approx;
    logic        busy;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    mul_share_sched #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_approx (req_approx),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_z      (rsp_z),
        .rsp_id     (rsp_id),
        .rsp_approx (rsp_approx),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_x      = '0;
        req_y      = '0;
        req_approx = '0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_z !== 16'd0) begin errors++; $display("FAIL reset_rsp_z got=%0d exp=0", rsp_z); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_approx !== 1'b0) begin errors++; $display("FAIL reset_rsp_approx got=%b exp=0", rsp_approx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_exact();
        logic [7:0]  xs [2] = '{8'd255, 8'd3};
        logic [7:0]  ys [2] = '{8'd255, 8'd200};
        logic [15:0] zs [2] = '{16'd65025, 16'd600};
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            req_x      = '0;
            req_y      = '0;
            req_approx = '0;
            req_x[7:0] = xs[v];
            req_y[7:0] = ys[v];
            req_valid  = 4'b0001;
            rsp_ready  = 1'b1;
            #1;
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL exact_grant v=%0d got=%b exp=0001", v, req_ready); end
            @(negedge clk);
            req_valid = '0;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL exact_latency1 v=%0d got=%b exp=0", v, rsp_valid); end
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL exact_latency2 v=%0d got=%b exp=1", v, rsp_valid); end
            checks++; if (rsp_z !== zs[v]) begin errors++; $display("FAIL exact_z v=%0d got=%0d exp=%0d", v, rsp_z, zs[v]); end
            checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL exact_id v=%0d got=%0d exp=0", v, rsp_id); end
            checks++; if (rsp_approx !== 1'b0) begin errors++; $display("FAIL exact_mode v=%0d got=%b exp=0", v, rsp_approx); end
        end
    endtask

    task automatic test_approx();
        logic [7:0]  xs [3] = '{8'd255, 8'd3, 8'd4};
        logic [7:0]  ys [3] = '{8'd255, 8'd200, 8'd10};
        logic [15:0] zs [3] = '{16'd64772, 16'd512, 16'd40};
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            req_x        = '0;
            req_y        = '0;
            req_approx   = '0;
            req_x[23:16] = xs[v];
            req_y[23:16] = ys[v];
            req_approx[2] = 1'b1;
            req_valid    = 4'b0100;
            rsp_ready    = 1'b1;
            #1;
            checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL approx_grant v=%0d got=%b exp=0100", v, req_ready); end
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL approx_valid v=%0d got=%b exp=1", v, rsp_valid); end
            checks++; if (rsp_z !== zs[v]) begin errors++; $display("FAIL approx_z v=%0d got=%0d exp=%0d", v, rsp_z, zs[v]); end
            checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL approx_id v=%0d got=%0d exp=2", v, rsp_id); end
            checks++; if (rsp_approx !== 1'b1) begin errors++; $display("FAIL approx_mode v=%0d got=%b exp=1", v, rsp_approx); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        apply_reset();
        req_x      = 32'h04030201;
        req_y      = 32'h05050505;
        req_approx = '0;
        rsp_ready  = 1'b1;
        req_valid  = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_gnt = 4'b0001 << (i % 4);
            checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL rr_grant i=%0d got=%b exp=%b", i, req_ready, exp_gnt); end
            if (i >= 2) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((i - 2) % 4)) begin
                    errors++; $display("FAIL rr_rsp i=%0d got valid=%b id=%0d exp valid=1 id=%0d", i, rsp_valid, rsp_id, (i - 2) % 4);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (op_count !== 16'd6) begin errors++; $display("FAIL rr_op_count got=%0d exp=6", op_count); end
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        int          got = 0;
        int          acc_bp = 0;
        logic [15:0] got_z [4];
        apply_reset();
        req_x      = '0;
        req_y      = '0;
        req_approx = '0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            rsp_ready     = (cyc >= 4);
            req_valid     = (sent < 4) ? 4'b0010 : 4'b0000;
            req_x[15:8]   = 8'(sent + 1);
            req_y[15:8]   = 8'd100;
            #1;
            if (cyc == 2 || cyc == 3) begin
                checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_full_ready cyc=%0d got=%b exp=0000", cyc, req_ready); end
                checks++; if (rsp_valid !== 1'b1 || rsp_z !== 16'd100) begin
                    errors++; $display("FAIL bp_hold cyc=%0d got valid=%b z=%0d exp valid=1 z=100", cyc, rsp_valid, rsp_z);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (got < 4) got_z[got] = rsp_z;
                got++;
            end
            if (req_ready[1]) begin
                sent++;
                if (cyc < 4) acc_bp++;
            end
            @(negedge clk);
        end
        checks++; if (acc_bp !== 2) begin errors++; $display("FAIL bp_accepts got=%0d exp=2", acc_bp); end
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_timeout got=%0d responses exp=4", got); end
        for (int k = 0; k < 4 && k < got; k++) begin
            checks++; if (got_z[k] !== 16'((k + 1) * 100)) begin
                errors++; $display("FAIL bp_order k=%0d got=%0d exp=%0d", k, got_z[k], (k + 1) * 100);
            end
        end
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%b exp=0", rsp_valid); end
        checks++; if (op_count !== 16'd4) begin errors++; $display("FAIL bp_op_count got=%0d exp=4", op_count); end
    endtask

    task automatic test_skip_idle();
        apply_reset();
        req_x      = 32'h00030002;
        req_y      = 32'h00070007;
        req_approx = '0;
        rsp_ready  = 1'b1;
        req_valid  = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_setup got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0101;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL skip_first got=%b exp=0100", req_ready); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_second got=%b exp=0001", req_ready); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL skip_third got=%b exp=0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        req_x      = 32'h07000000;
        req_y      = 32'h09000000;
        req_approx = '0;
        rsp_ready  = 1'b0;
        req_valid  = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL areset_full got busy=%b valid=%b ready=%b exp 1 1 0000", busy, rsp_valid, req_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (rsp_z !== 16'd0) begin errors++; $display("FAIL areset_z got=%0d exp=0", rsp_z); end
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL areset_op_count got=%0d exp=0", op_count); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL areset_req_ready got=%b exp=0000", req_ready); end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
        for (int c = 0; c < 6 && !seen; c++) begin
            if (rsp_valid) seen = 1;
            else @(negedge clk);
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL areset_timeout got no response exp one"); end
        checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL areset_first_id got=%0d exp=3", rsp_id); end
        checks++; if (rsp_z !== 16'd63) begin errors++; $display("FAIL areset_first_z got=%0d exp=63", rsp_z); end
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL areset_count0 got=%0d exp=0", op_count); end
        @(negedge clk);
        checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL areset_count1 got=%0d exp=1", op_count); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL areset_stale got=%b exp=0", rsp_valid); end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        req_approx = '0;
        rsp_ready  = 1'b0;
        test_reset();
        test_exact();
        test_approx();
        test_round_robin();
        test_backpressure();
        test_skip_idle();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_share_sched.md
Name: mul_share_sched

Overview:
- Round-robin scheduler that shares one 8x8 unsigned multiplier among N_REQ requesters.
- Each request picks exact mode or the l=2 approximate mode.
- Two-stage registered pipeline (operand stage, product stage) with valid/ready handshakes on both sides, plus a completed-operation counter.
- Sits between the accelerator's operand producers and its accumulate stage.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= N_REQ.
- CNT_W, 16, width of the completion counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit is high per cycle.
- req_x  in  N_REQ*8  operand x, where requester i uses bits [8i+7:8i].
- req_y  in  N_REQ*8  operand y, same packing as req_x.
- req_approx  in  N_REQ  1 selects approximate mode, 0 selects exact mode.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_z  out  16  product.
- rsp_id  out  ID_W  index of the requester that issued the result.
- rsp_approx  out  1  mode used for this result.
- busy  out  1  high when either pipeline stage holds valid data.
- op_count  out  CNT_W  count of completed responses; wraps modulo 2**CNT_W.

Behaviour:
- Reset: all outputs 0 (req_ready=0, rsp_valid=0, rsp_z=0, rsp_id=0, rsp_approx=0, busy=0, op_count=0). Stage valids clear; round-robin pointer = 0.
- Reset mid-operation: in-flight operations are dropped and never reported.
- Stage readiness:
  - s2_ready = !s2_valid || rsp_ready.
  - s1_ready = !s1_valid || s2_ready.
- Arbitration (combinational):
  - When s1_ready, grant the first i with req_valid[i] set, searching from ptr upward with wrap.
  - req_ready = one-hot grant; all zero if !s1_ready or no request is valid.
  - req_ready may depend on req_valid. Requesters hold valid and operands stable until accepted.
- On accept of requester g:
  - s1 captures x, y, approx, id = g.
  - ptr <= (g+1) mod N_REQ.
  - With no accept, ptr holds.
- s1 -> s2 transfer (when s2_ready):
  - s2 captures the product of the s1 operands, id and approx.
  - s1_valid <= accept_this_cycle. Simultaneous drain and refill is allowed, giving full throughput of 1 op/cycle.
- Output: rsp_* are driven directly from s2 registers. Latency is 2 cycles from accept to rsp_valid.
- Backpressure:
  - While rsp_valid && !rsp_ready, rsp_z, rsp_id and rsp_approx hold stable.
  - The pipeline holds at most 2 operations; with both stages full, req_ready = 0.
- Exact mode: z = x*y, a full 16-bit result with no overflow.
- Approximate mode (16-bit result, sum cannot overflow): z = ((y * x[7:2]) << 2) + (((x[0]&y[7]) | (x[1]&y[6])) << 8) + ((x[1]&y[7]) << 8).
- op_count increments on each rsp_valid && rsp_ready.
- busy = s1_valid || s2_valid.

Decomposition:
- Package mul_share_pkg holds:
  - OP_W=8 and P_W=16.
  - APPROX_L=2 (number of truncated x bits).
  - CORR_POS=8 (bit position of the correction terms).
  - A request struct {x, y, approx, id}.
- Sub-module mul_mode_unit: purely combinational, takes x, y, approx and produces z. Both formulas live here so the multiplier can be swapped without touching the scheduler.
- The arbiter is inline: a pointer plus a rotate-priority encoder.

Test Plan:
- Exact: req0 x=255, y=255, approx=0, rsp_ready=1 -> rsp_z=65025, rsp_id=0, exactly 2 cycles after accept. Same for x=3, y=200 -> 600.
- Approximate: x=255, y=255, approx=1 -> 64772. x=3, y=200 -> 512. x=4, y=10 -> 40 (no correction terms, result equals exact).
- Round-robin: all 4 requesters hold valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,1. One grant per cycle; op_count=6 after 8 cycles.
- Backpressure: stream from req1 with rsp_ready=0 for 4 cycles -> exactly 2 accepts, then req_ready=0 and rsp_z held stable. After rsp_ready returns to 1, results arrive in order with no loss or duplication.
- Skip idle requesters: only req2 and req0 valid, ptr=1 -> grant req2, then req0, then req2.
- Async reset with both stages full -> outputs 0 immediately, without waiting for a clock edge. After release, a new req3 request has first response rsp_id=3, and op_count restarts from 0.
